// File: rtl/conv3x3_window_sequencer.sv
// Frame controller for the 3x3 sharpening MAC: gathers windows from the pixel RAM, strobes the MAC,
// clamps each result to 8 bits and hands it to the sink. Define WINDOW_REUSE_EN to fetch only the new column per step.
module conv3x3_window_sequencer #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [7:0]               rd_data,
    output logic signed [8:0]        win_pix [9],
    output logic                     mac_stall,
    input  logic signed [20:0]       mac_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [7:0]               out_pix
);

`ifdef WINDOW_REUSE_EN
    localparam logic REUSE = 1'b1;
`else
    localparam logic REUSE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, COMPUTE, CAPTURE, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] r, c, out_idx;
    logic [1:0]        kr, kc;
    logic              reuse;
    logic              cap_vld_p1;
    logic [3:0]        cap_idx_p1;
    logic              last_k, last_c, last_pos;

    function automatic logic [7:0] clamp_u8(input logic signed [20:0] v);
        if (v < 0) return 8'd0;
        if (v > 21'sd255) return 8'd255;
        return v[7:0];
    endfunction

    assign last_k   = (kr == 2'd2) && (kc == 2'd2);
    assign last_c   = (c == ADDR_W'(WIDTH-3));
    assign last_pos = last_c && (r == ADDR_W'(HEIGHT-3));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (last_k) state_nxt = DRAIN;
            DRAIN:   state_nxt = COMPUTE;
            COMPUTE: state_nxt = CAPTURE;
            CAPTURE: state_nxt = WRITE;
            WRITE:   if (out_ready) state_nxt = last_pos ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_en     = (state == FETCH);
        rd_addr   = '0;
        if (state == FETCH)
            rd_addr = (r + ADDR_W'(kr)) * ADDR_W'(WIDTH) + c + ADDR_W'(kc);
        mac_stall = (state != COMPUTE);
        out_valid = (state == WRITE);
        out_addr  = out_idx;
    end

    // Window offset walk (kr,kc), window position (r,c) and output index
    always_ff @(posedge clk) begin
        if (reset) begin
            r       <= '0;
            c       <= '0;
            kr      <= '0;
            kc      <= '0;
            reuse   <= 1'b0;
            out_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    r       <= '0;
                    c       <= '0;
                    kr      <= '0;
                    kc      <= '0;
                    reuse   <= 1'b0;
                    out_idx <= '0;
                end
                FETCH: if (!last_k) begin
                    if (reuse || kc == 2'd2) begin
                        kr <= kr + 1'b1;
                        kc <= reuse ? 2'd2 : 2'd0;
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                WRITE: if (out_ready) begin
                    kr      <= '0;
                    out_idx <= last_pos ? '0 : out_idx + 1'b1;
                    if (last_c) begin
                        c     <= '0;
                        r     <= last_pos ? '0 : r + 1'b1;
                        kc    <= '0;
                        reuse <= 1'b0;
                    end else begin
                        c     <= c + 1'b1;
                        kc    <= REUSE ? 2'd2 : 2'd0;
                        reuse <= REUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    // p1: RAM data returns one cycle after the strobe; land it in the element issued then
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_vld_p1 <= 1'b0;
            cap_idx_p1 <= '0;
            out_pix    <= '0;
            for (int i = 0; i < 9; i++) win_pix[i] <= '0;
        end else begin
            cap_vld_p1 <= rd_en;
            cap_idx_p1 <= {2'b00, kr} * 4'd3 + {2'b00, kc};
            if (cap_vld_p1)
                win_pix[cap_idx_p1] <= {1'b0, rd_data};
            if (state == CAPTURE)
                out_pix <= clamp_u8(mac_out);
            if (REUSE && state == WRITE && out_ready && !last_c) begin
                for (int row = 0; row < 3; row++) begin
                    win_pix[row*3]   <= win_pix[row*3+1];
                    win_pix[row*3+1] <= win_pix[row*3+2];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window_sequencer.sv
// Randomized bench for conv3x3_window_sequencer on a 5x4 image with a behavioural pixel RAM and sharpening MAC.
`timescale 1ns/1ps
module tb_conv3x3_window_sequencer;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int AW   = $clog2(W*H);
    localparam int NWIN = (W-2)*(H-2);
`ifdef WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, busy, done, rd_en, mac_stall, out_valid, out_ready;
    logic [AW-1:0] rd_addr, out_addr;
    logic [7:0] rd_data, out_pix;
    logic signed [8:0] win_pix [9];
    logic signed [20:0] mac_out;

    int img [W*H];
    int coef [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    int n_chk = 0;
    int n_err = 0;
    int rd_log[$];
    int wa_log[$];
    int wp_log[$];
    int lat;
    bit got_done;

    always #5 clk = ~clk;

    conv3x3_window_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win_pix(win_pix),
        .mac_stall(mac_stall), .mac_out(mac_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_pix(out_pix)
    );

    // Pixel RAM: one-cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= 8'(img[rd_addr]);

    function automatic int mac_dot();
        int s = 0;
        for (int i = 0; i < 9; i++) s += coef[i] * int'(win_pix[i]);
        return s;
    endfunction

    // MAC: result registered on the un-stalled cycle, held otherwise
    always @(posedge clk) if (!mac_stall) mac_out <= 21'(mac_dot());

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += coef[i*3+j] * img[(r+i)*W + c + j];
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic check_reset(input string tag);
        int nz = 0;
        for (int i = 0; i < 9; i++) if (win_pix[i] != 0) nz++;
        check_val($sformatf("%s rd_en", tag), rd_en, 0);
        check_val($sformatf("%s rd_addr", tag), rd_addr, 0);
        check_val($sformatf("%s win_nonzero", tag), nz, 0);
        check_val($sformatf("%s mac_stall", tag), mac_stall, 1);
        check_val($sformatf("%s out_valid", tag), out_valid, 0);
        check_val($sformatf("%s out_addr", tag), out_addr, 0);
        check_val($sformatf("%s out_pix", tag), out_pix, 0);
        check_val($sformatf("%s busy", tag), busy, 0);
        check_val($sformatf("%s done", tag), done, 0);
    endtask

    // Runs one frame; bp = cycles of out_ready low in the first WRITE, poke = pulse start in every COMPUTE
    task automatic run_frame(input int bp, input bit poke);
        int t = 0;
        int left = bp;
        bit seen_v = 1'b0;
        bit chk_drop = 1'b0;
        rd_log.delete(); wa_log.delete(); wp_log.delete();
        lat = -1;
        got_done = 1'b0;
        out_ready = (bp == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_rise", busy, 1);
        while (!got_done && t < 3000) begin
            @(negedge clk);
            if (chk_drop) begin
                check_val("bp_advance_valid", out_valid, 0);
                chk_drop = 1'b0;
            end
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (out_valid && out_ready) begin
                wa_log.push_back(int'(out_addr));
                wp_log.push_back(int'(out_pix));
                if (bp > 0 && wa_log.size() == 1) chk_drop = 1'b1;
            end
            if (bp > 0 && out_valid && left > 0) seen_v = 1'b1;
            if (seen_v && left > 0) begin
                check_val("bp_valid", out_valid, 1);
                check_val("bp_pix", out_pix, ref_pix(0, 0));
                check_val("bp_addr", out_addr, 0);
                check_val("bp_rd_en", rd_en, 0);
                check_val("bp_stall", mac_stall, 1);
                left--;
            end
            if (done) begin
                got_done = 1'b1;
                lat = t;
            end
            if (poke && !mac_stall) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            t++;
            if (left == 0) out_ready = 1'b1;
        end
        check_val("done_seen", got_done, 1);
        check_val("busy_fall", busy, 0);
    endtask

    task automatic check_frame(input string name, input int extra);
        int exp_rd[$];
        int n;
        for (int r = 0; r < H-2; r++)
            for (int c = 0; c < W-2; c++) begin
                if (REUSE && c > 0) begin
                    for (int i = 0; i < 3; i++) exp_rd.push_back((r+i)*W + c + 2);
                end else begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) exp_rd.push_back((r+i)*W + c + j);
                end
            end
        check_val($sformatf("%s n_writes", name), wa_log.size(), NWIN);
        n = (wa_log.size() < NWIN) ? wa_log.size() : NWIN;
        for (int k = 0; k < n; k++) begin
            check_val($sformatf("%s out_addr[%0d]", name, k), wa_log[k], k);
            check_val($sformatf("%s out_pix[%0d]", name, k), wp_log[k], ref_pix(k / (W-2), k % (W-2)));
        end
        check_val($sformatf("%s n_reads", name), rd_log.size(), exp_rd.size());
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int k = 0; k < n; k++)
            check_val($sformatf("%s rd_addr[%0d]", name, k), rd_log[k], exp_rd[k]);
        check_val($sformatf("%s latency", name), lat, exp_rd.size() + 4*NWIN + extra);
    endtask

    task automatic rand_img();
        for (int i = 0; i < W*H; i++) img[i] = int'($urandom_range(0, 255));
    endtask

    initial begin
        int exp_win[$];
        int base;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // uniform image passes through the unity-gain sharpen unchanged
        for (int i = 0; i < W*H; i++) img[i] = 100;
        run_frame(0, 1'b0);
        check_frame("uniform", 0);
        check_val("uniform_pix0", (wp_log.size() > 0) ? wp_log[0] : -1, 100);

        // clamp high: isolated 255 gives 1275
        for (int i = 0; i < W*H; i++) img[i] = 0;
        img[1*W+1] = 255;
        run_frame(0, 1'b0);
        check_frame("clamp_hi", 0);
        check_val("clamp_hi_pix0", (wp_log.size() > 0) ? wp_log[0] : -1, 255);

        // clamp low: isolated 0 in 255 gives -1020
        for (int i = 0; i < W*H; i++) img[i] = 255;
        img[1*W+1] = 0;
        run_frame(0, 1'b0);
        check_frame("clamp_lo", 0);
        check_val("clamp_lo_pix0", (wp_log.size() > 0) ? wp_log[0] : -1, 0);

        rand_img();
        run_frame(5, 1'b0);
        check_frame("backpressure", 5);

        // reset on the 4th FETCH cycle
        rand_img();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("rst_in_fetch", rd_en, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        repeat (3) @(negedge clk);
        check_val("mid_rst_quiet_valid", out_valid, 0);
        check_val("mid_rst_quiet_busy", busy, 0);
        @(posedge clk); #1;
        run_frame(0, 1'b0);
        check_frame("after_rst", 0);

        rand_img();
        run_frame(0, 1'b1);
        check_frame("start_busy", 0);

        // ramp image: window (1,2) is the last one of the frame
        for (int i = 0; i < W*H; i++) img[i] = i;
        run_frame(0, 1'b0);
        check_frame("ramp", 0);
        if (REUSE) begin
            exp_win = '{9, 14, 19};
            base = 27;
        end else begin
            exp_win = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
            base = 45;
        end
        for (int k = 0; k < exp_win.size(); k++)
            check_val($sformatf("ramp_win12[%0d]", k),
                      (base + k < rd_log.size()) ? rd_log[base+k] : -1, exp_win[k]);

        for (int n = 0; n < 3; n++) begin
            rand_img();
            run_frame(0, 1'b0);
            check_frame($sformatf("random%0d", n), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_sequencer.md
Name: conv3x3_window_sequencer

Overview:
Frame-level controller for the 3x3 convolution MAC (sharpening engine). On `start` it scans a WIDTH x HEIGHT 8-bit image held in a pixel RAM and gathers each 3x3 window. It presents the window to the MAC and gates the MAC's stall input. It clamps each 21-bit result to 8 bits and writes it to the output sink with a valid/ready handshake. Output covers valid positions only: (WIDTH-2) x (HEIGHT-2) pixels, row-major.

Parameters:
- WIDTH, 8, image width in pixels, minimum 3.
- HEIGHT, 8, image height in pixels, minimum 3.
- ADDR_W, $clog2(WIDTH*HEIGHT), width of the read and write addresses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at end of frame
- rd_en  out  1  pixel RAM read strobe
- rd_addr  out  ADDR_W  pixel RAM address
- rd_data  in  8  unsigned pixel; valid the cycle after rd_en
- win_pix  out  9x9 signed  window to MAC, row-major; each element is {1'b0, pixel}
- mac_stall  out  1  MAC stall; low for exactly one cycle per window
- mac_out  in  21 signed  MAC result; valid the cycle after the mac_stall-low cycle
- out_valid  out  1  result valid
- out_ready  in  1  sink ready
- out_addr  out  ADDR_W  output index r*(WIDTH-2)+c
- out_pix  out  8  clamped result

Behaviour:
- Reset values: rd_en=0, rd_addr=0, win_pix all 0, mac_stall=1, out_valid=0, out_addr=0, out_pix=0, busy=0, done=0. FSM goes to IDLE and r=c=0.
- Reset mid-frame aborts immediately, with the same values as above. No partial write follows.
- Position registers: r in 0..HEIGHT-3 and c in 0..WIDTH-3 give the top-left corner of the window.
- IDLE:
  - start=1 moves to FETCH with r=c=0, k=0. busy=1 from the next cycle.
  - start is ignored in every other state.
- FETCH:
  - Element k=0..8 is issued one per cycle: rd_en=1, rd_addr=(r+k/3)*WIDTH + c + k%3.
  - rd_data captured in the following cycle is stored into win[k-1] (the element issued one cycle earlier).
  - After k=8, go to DRAIN.
- DRAIN: rd_en=0; capture element 8. Go to COMPUTE.
- COMPUTE: mac_stall=0 for this cycle only; win_pix is stable. Go to CAPTURE.
- CAPTURE:
  - Read mac_out and clamp it: <0 gives 0; >255 gives 255; otherwise take the low 8 bits.
  - Register the clamped value into out_pix and set out_valid=1. Go to WRITE.
- WRITE:
  - Hold out_valid, out_pix and out_addr stable until out_valid&&out_ready.
  - On the handshake, drop out_valid and advance c. At c wrap, c=0 and r++.
  - Last position (r=HEIGHT-3, c=WIDTH-3) goes to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, busy=0 from the next cycle. Go to IDLE.
- Latency with out_ready tied high is 13 cycles per output pixel (FETCH 9, DRAIN, COMPUTE, CAPTURE, WRITE 1).
- mac_stall=1 in every state other than COMPUTE, so the MAC holds its last result.
- rd_en=0 outside FETCH.

Optional Feature:
WINDOW_REUSE_EN
- Defined:
  - When c advances within a row (new c>0), shift win columns left (win[0,1]<-win[1,2], and likewise for the other rows).
  - FETCH then issues only column c+2, for k=2,5,8 in that order, so 3 reads per window.
  - The first window of each row still uses 9 reads.
  - Per-pixel latency drops to 7 cycles. Results are identical.
- Undefined: 9 reads for every window, as in Behaviour.

Test Plan:
1. Uniform 100:
   - Stimulus: 4x4 image of all 100; MAC filter [0 -1 0; -1 5 -1; 0 -1 0]; out_ready=1; start.
   - Required: 4 writes, out_addr 0..3, all out_pix=100, done 52 cycles after busy rises (macro off); rd_en count 36 (24 with macro).
2. Clamp high and low:
   - Stimulus: 3x3 image with centre 255 and others 0, then centre 0 and others 255.
   - Required: out_pix=255 (mac_out=1275), then out_pix=0 (mac_out=-1020).
3. Backpressure:
   - Stimulus: out_ready low for 5 cycles in the first WRITE.
   - Required: out_valid held, out_pix/out_addr stable, rd_en=0, mac_stall=1 throughout; advance on the first ready cycle.
4. Reset mid-FETCH:
   - Stimulus: assert reset on the 4th FETCH cycle.
   - Required: next cycle all outputs at reset values and busy=0; a fresh start produces the full, correct frame.
5. Start while busy:
   - Stimulus: pulse start during COMPUTE.
   - Required: no restart, and the output sequence is unchanged.
6. Address sweep:
   - Stimulus: 5x4 ramp image, pixel = address.
   - Required: rd_addr sequence for window (1,2) is 7,8,9,12,13,14,17,18,19 (macro off), or 9,14,19 (macro on).
